philo_monitor: RTL and testbench
================================

PHILO_MONITOR -- requirements
Module: philo_monitor

Interface
REQ-001 Parameter HUNGER_LIMIT, default 15, is the number of consecutive HUNGRY samples that flags starvation; its legal range is 1..255.
REQ-002 Parameter CNT_W, default 8, is the width of each per-philosopher eat counter.
REQ-003 Port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-005 Ports st0, st1, st2, st3, input, 2 bits each: the philosopher state buses, encoded THINKING=0, READING=1, EATING=2, HUNGRY=3.
REQ-006 Ring adjacency is fixed: philosopher i neighbours i+1 mod 4 and i-1 mod 4.
REQ-007 Port clr, input, 1 bit: synchronous clear of all flags and counters.
REQ-008 Port mutex_err, output, 1 bit: sticky flag, set when two adjacent philosophers are EATING together.
REQ-009 Port trans_err, output, 4 bits: sticky flags, bit i set on an illegal state transition of philosopher i.
REQ-010 Port starve, output, 4 bits: sticky flags, bit i set when philosopher i starves.
REQ-011 Ports eat_cnt0, eat_cnt1, eat_cnt2, eat_cnt3, output, CNT_W bits each: the number of HUNGRY->EATING transitions of each philosopher.
REQ-012 Port any_err, output, 1 bit: the OR of mutex_err, all trans_err bits and all starve bits.

Function
REQ-013 All outputs shall be registered, except any_err, which is combinational from registered flags.
REQ-014 Each rising edge samples st0..st3; a condition present at edge k is visible on the outputs immediately after edge k.
REQ-015 The block shall hold prev_i (2 bits) per philosopher plus a single prev_valid bit; both load on every edge.
- prev_valid is 0 after reset or clr.
- prev_valid becomes 1 at the first edge after reset or clr.
REQ-016 The legal transitions, from prev_i to st_i, shall be exactly these:
- THINKING -> THINKING, READING or HUNGRY;
- READING -> READING or THINKING;
- EATING -> EATING or THINKING;
- HUNGRY -> HUNGRY or EATING.
REQ-017 trans_err[i] shall set at an edge where prev_valid=1 and the transition prev_i -> st_i is illegal.
REQ-018 No transition check shall occur while prev_valid=0.
REQ-019 mutex_err shall set at any edge where some pair (i, i+1 mod 4) both sample EATING; all four pairs are checked, including the 3-0 wrap pair.
REQ-020 Each philosopher shall have a hunger counter hcnt_i, width 8, behaving as follows:
- increments at an edge where st_i=HUNGRY;
- clears to 0 at an edge where st_i is not HUNGRY;
- saturates at HUNGER_LIMIT.
REQ-021 starve[i] shall set at the same edge where hcnt_i becomes HUNGER_LIMIT, i.e. on the HUNGER_LIMIT-th consecutive HUNGRY sample.
REQ-022 After starve[i] sets it shall remain set even if philosopher i later eats.
REQ-023 eat_cnt_i shall increment by 1 at an edge where prev_valid=1, prev_i=HUNGRY and st_i=EATING.
REQ-024 eat_cnt_i shall saturate at 2^CNT_W-1 and shall not wrap.
REQ-025 All flags shall be sticky: once set, only reset_n or clr clears them.
REQ-026 clr=1 at an edge shall clear all flags, all counters, all hcnt and prev_valid.
REQ-027 On clr, the clear shall take priority over any event sampled at that same edge; that event is neither flagged nor counted.
REQ-028 Multiple simultaneous events at one edge shall all be recorded independently, for example mutex_err, trans_err[2] and starve[0] together.

Reset
REQ-029 reset_n=0 shall asynchronously force to 0: mutex_err, trans_err, starve, eat_cnt0..3, every hcnt_i, prev_i and prev_valid.
REQ-030 any_err shall be 0 while reset_n=0.
REQ-031 Reset asserted mid-operation, including mid-hunger-run, shall discard all history; the first edge after release shall perform no transition check.
REQ-032 reset_n deassertion shall be synchronised externally; the block requires no reset synchroniser.

Verification
REQ-033 Eat counting: st0 driven THINKING, HUNGRY, HUNGRY, EATING, THINKING, one state per edge, others THINKING -> eat_cnt0=1 after the EATING edge, all flags 0.
REQ-034 Starvation: st2=HUNGRY for 14 edges -> starve=0; at the 15th edge -> starve=4'b0100 and any_err=1; st2=EATING next -> starve stays 4'b0100 and eat_cnt2=1.
REQ-035 Mutex wrap pair: st3=EATING and st0=EATING at the same edge -> mutex_err=1 at that edge; st1/st2 EATING pairs are checked likewise.
REQ-036 Illegal transition: st1 READING then EATING -> trans_err=4'b0010; the first sample after reset_n release is EATING with no error -> no trans_err.
REQ-037 Clear priority: clr=1 in the same cycle as st0 HUNGRY->EATING -> eat_cnt0=0 and all flags 0; the next legal event is counted normally.
REQ-038 Saturation: with CNT_W=2, five HUNGRY->EATING cycles on st3 -> eat_cnt3=3; reset_n pulsed low mid-run -> all outputs 0 immediately, asynchronously.

Source files
------------

// File: rtl/philo_monitor.sv
// philo_monitor
// Watches a ring of four dining philosophers and records protocol violations
// and per-philosopher statistics. All flags are sticky until reset_n or clr.
//
// Ports
//   clock              : single clock, rising edge
//   reset_n            : asynchronous active-low reset
//   st0..st3 [1:0]     : philosopher states (THINKING=0 READING=1 EATING=2 HUNGRY=3)
//   clr                : synchronous clear of all flags, counters and history
//   mutex_err          : two ring neighbours were EATING at the same edge
//   trans_err [3:0]    : bit i = illegal state transition by philosopher i
//   starve [3:0]       : bit i = philosopher i was HUNGRY for HUNGER_LIMIT edges
//   eat_cnt0..3        : saturating count of HUNGRY->EATING transitions
//   any_err            : OR of all error flags (combinational from registers)
module philo_monitor #(
    parameter int HUNGER_LIMIT = 15,
    parameter int CNT_W        = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [1:0]       st0,
    input  logic [1:0]       st1,
    input  logic [1:0]       st2,
    input  logic [1:0]       st3,
    input  logic             clr,
    output logic             mutex_err,
    output logic [3:0]       trans_err,
    output logic [3:0]       starve,
    output logic [CNT_W-1:0] eat_cnt0,
    output logic [CNT_W-1:0] eat_cnt1,
    output logic [CNT_W-1:0] eat_cnt2,
    output logic [CNT_W-1:0] eat_cnt3,
    output logic             any_err
);

    localparam logic [1:0] THINKING = 2'd0;
    localparam logic [1:0] READING  = 2'd1;
    localparam logic [1:0] EATING   = 2'd2;
    localparam logic [1:0] HUNGRY   = 2'd3;
    localparam logic [7:0] LIMIT    = 8'(HUNGER_LIMIT);

    logic [3:0][1:0]       st;
    logic [3:0][1:0]       prev;
    logic                  prev_valid;
    logic [3:0][7:0]       hcnt;
    logic [3:0][7:0]       hcnt_nxt;
    logic [3:0][CNT_W-1:0] eat_cnt;
    logic [3:0][CNT_W-1:0] eat_nxt;
    logic [3:0]            trans_hit;
    logic [3:0]            starve_hit;
    logic                  mutex_hit;

    assign st = {st3, st2, st1, st0};

    function automatic logic legal(input logic [1:0] from, input logic [1:0] to);
        case (from)
            THINKING: legal = (to != EATING);
            READING:  legal = (to == READING) || (to == THINKING);
            EATING:   legal = (to == EATING)  || (to == THINKING);
            default:  legal = (to == HUNGRY)  || (to == EATING);
        endcase
    endfunction

    always_comb begin
        mutex_hit  = 1'b0;
        trans_hit  = '0;
        starve_hit = '0;
        hcnt_nxt   = '0;
        eat_nxt    = eat_cnt;
        for (int i = 0; i < 4; i++) begin
            // 2-bit cast wraps the index, so pair 3-0 is covered
            if (st[i] == EATING && st[2'(i + 1)] == EATING)
                mutex_hit = 1'b1;
            trans_hit[i] = prev_valid && !legal(prev[i], st[i]);
            if (st[i] == HUNGRY)
                hcnt_nxt[i] = (hcnt[i] == LIMIT) ? LIMIT : hcnt[i] + 8'd1;
            // LIMIT >= 1, so a cleared counter never matches
            starve_hit[i] = (hcnt_nxt[i] == LIMIT);
            if (prev_valid && prev[i] == HUNGRY && st[i] == EATING && eat_cnt[i] != '1)
                eat_nxt[i] = eat_cnt[i] + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prev       <= '0;
            prev_valid <= 1'b0;
            hcnt       <= '0;
            eat_cnt    <= '0;
            mutex_err  <= 1'b0;
            trans_err  <= '0;
            starve     <= '0;
        end else begin
            prev <= st;
            if (clr) begin
                prev_valid <= 1'b0;
                hcnt       <= '0;
                eat_cnt    <= '0;
                mutex_err  <= 1'b0;
                trans_err  <= '0;
                starve     <= '0;
            end else begin
                prev_valid <= 1'b1;
                hcnt       <= hcnt_nxt;
                eat_cnt    <= eat_nxt;
                mutex_err  <= mutex_err | mutex_hit;
                trans_err  <= trans_err | trans_hit;
                starve     <= starve | starve_hit;
            end
        end
    end

    assign eat_cnt0 = eat_cnt[0];
    assign eat_cnt1 = eat_cnt[1];
    assign eat_cnt2 = eat_cnt[2];
    assign eat_cnt3 = eat_cnt[3];
    assign any_err  = mutex_err | (|trans_err) | (|starve);

endmodule

// File: tb/tb_philo_monitor.sv
// Directed bench for philo_monitor. Two instances share stimulus: one with
// default parameters, one with CNT_W=2 to exercise eat counter saturation.
module tb_philo_monitor;

    localparam logic [1:0] T = 2'd0;
    localparam logic [1:0] R = 2'd1;
    localparam logic [1:0] E = 2'd2;
    localparam logic [1:0] H = 2'd3;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       clr;
    logic [1:0] s [4];

    logic       mutex_err, any_err;
    logic [3:0] trans_err, starve;
    logic [7:0] eat_cnt0, eat_cnt1, eat_cnt2, eat_cnt3;

    logic       n_mutex_err, n_any_err;
    logic [3:0] n_trans_err, n_starve;
    logic [1:0] n_eat_cnt0, n_eat_cnt1, n_eat_cnt2, n_eat_cnt3;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    philo_monitor dut (
        .clock(clock), .reset_n(reset_n),
        .st0(s[0]), .st1(s[1]), .st2(s[2]), .st3(s[3]), .clr(clr),
        .mutex_err(mutex_err), .trans_err(trans_err), .starve(starve),
        .eat_cnt0(eat_cnt0), .eat_cnt1(eat_cnt1), .eat_cnt2(eat_cnt2), .eat_cnt3(eat_cnt3),
        .any_err(any_err)
    );

    philo_monitor #(.CNT_W(2)) dut_n (
        .clock(clock), .reset_n(reset_n),
        .st0(s[0]), .st1(s[1]), .st2(s[2]), .st3(s[3]), .clr(clr),
        .mutex_err(n_mutex_err), .trans_err(n_trans_err), .starve(n_starve),
        .eat_cnt0(n_eat_cnt0), .eat_cnt1(n_eat_cnt1), .eat_cnt2(n_eat_cnt2), .eat_cnt3(n_eat_cnt3),
        .any_err(n_any_err)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic all_think();
        for (int i = 0; i < 4; i++) s[i] = T;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_mutex"}, 32'(mutex_err), 32'd0);
        check_val({tag, "_trans"}, 32'(trans_err), 32'd0);
        check_val({tag, "_starve"}, 32'(starve), 32'd0);
        check_val({tag, "_eat"}, {eat_cnt3, eat_cnt2, eat_cnt1, eat_cnt0}, 32'd0);
        check_val({tag, "_any"}, 32'(any_err), 32'd0);
        check_val({tag, "_n_eat"}, 32'({n_eat_cnt3, n_eat_cnt2, n_eat_cnt1, n_eat_cnt0}), 32'd0);
        check_val({tag, "_n_flags"}, 32'({n_mutex_err, n_trans_err, n_starve, n_any_err}), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        clr     = 1'b0;
        all_think();
        #2;
        check_zero("reset");
        #10;
        reset_n = 1'b1;

        // first sample after release is EATING from reset prev: no check
        s[1] = E;
        tick();
        check_val("first_eat_trans", 32'(trans_err), 32'd0);
        s[1] = T;
        tick();
        check_val("first_eat_any", 32'(any_err), 32'd0);

        // eat counting on philosopher 0
        s[0] = T; tick();
        s[0] = H; tick();
        s[0] = H; tick();
        s[0] = E; tick();
        check_val("eat0_cnt", 32'(eat_cnt0), 32'd1);
        check_val("eat0_n_cnt", 32'(n_eat_cnt0), 32'd1);
        s[0] = T; tick();
        check_val("eat0_cnt_hold", 32'(eat_cnt0), 32'd1);
        check_val("eat0_any", 32'(any_err), 32'd0);

        // illegal READING -> EATING on philosopher 1
        s[1] = R; tick();
        check_val("read_trans", 32'(trans_err), 32'd0);
        s[1] = E; tick();
        check_val("illegal_trans", 32'(trans_err), 32'b0010);
        check_val("illegal_any", 32'(any_err), 32'd1);
        s[1] = T; tick();
        check_val("illegal_sticky", 32'(trans_err), 32'b0010);
        do_clr();
        check_zero("clr1");

        // starvation on philosopher 2
        s[2] = H;
        for (int k = 0; k < 14; k++) tick();
        check_val("starve_14", 32'(starve), 32'd0);
        tick();
        check_val("starve_15", 32'(starve), 32'b0100);
        check_val("starve_any", 32'(any_err), 32'd1);
        s[2] = E; tick();
        check_val("starve_sticky", 32'(starve), 32'b0100);
        check_val("starve_eat2", 32'(eat_cnt2), 32'd1);
        check_val("starve_trans", 32'(trans_err), 32'd0);
        s[2] = T; tick();
        do_clr();

        // every adjacent pair, including the 3-0 wrap
        for (int p = 0; p < 4; p++) begin
            s[p] = H; s[(p + 1) % 4] = H; tick();
            check_val($sformatf("pair%0d_pre", p), 32'(mutex_err), 32'd0);
            s[p] = E; s[(p + 1) % 4] = E; tick();
            check_val($sformatf("pair%0d_mutex", p), 32'(mutex_err), 32'd1);
            check_val($sformatf("pair%0d_trans", p), 32'(trans_err), 32'd0);
            all_think(); tick();
            do_clr();
        end

        // non-adjacent philosophers may eat together
        s[0] = H; s[2] = H; tick();
        s[0] = E; s[2] = E; tick();
        check_val("opposite_mutex", 32'(mutex_err), 32'd0);
        check_val("opposite_eat", 32'({eat_cnt2, eat_cnt0}), 32'h0101);
        all_think(); tick();
        do_clr();

        // clear beats an event at the same edge
        s[0] = H; tick();
        s[0] = E; clr = 1'b1; tick();
        clr = 1'b0;
        check_val("clrpri_eat0", 32'(eat_cnt0), 32'd0);
        check_val("clrpri_any", 32'(any_err), 32'd0);
        s[0] = T; tick();
        s[0] = H; tick();
        s[0] = E; tick();
        check_val("clrpri_next", 32'(eat_cnt0), 32'd1);
        all_think(); tick();
        do_clr();

        // saturation on philosopher 3
        for (int k = 0; k < 5; k++) begin
            s[3] = H; tick();
            s[3] = E; tick();
            s[3] = T; tick();
        end
        check_val("sat_n_eat3", 32'(n_eat_cnt3), 32'd3);
        check_val("sat_eat3", 32'(eat_cnt3), 32'd5);
        check_val("sat_trans", 32'(trans_err), 32'd0);

        // asynchronous reset mid-hunger
        s[3] = H; s[2] = R; tick();
        s[2] = E; tick();
        check_val("pre_rst_trans", 32'(trans_err), 32'b0100);
        #2;
        reset_n = 1'b0;
        #1;
        check_zero("async_rst");
        @(negedge clock);
        reset_n = 1'b1;
        s[3] = T; s[2] = T; s[1] = E;
        tick();
        check_val("post_rst_trans", 32'(trans_err), 32'd0);
        check_val("post_rst_any", 32'(any_err), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
